abus_arbiter_lock: RTL and testbench



---
 rtl/abus_arbiter_lock.sv | 220 ++++++++++++++++++++++
 tb/tb_abus_arbiter_lock.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/abus_arbiter_lock.sv
// ABUS interconnect arbiter: locks the winning master onto its decoded slave until ack/abort.
// Optional transaction watchdog enabled by defining ABUS_ARB_TIMEOUT_EN.
module abus_arbiter_lock #(
    parameter int NB_MASTER  = 4,
    parameter int NB_SLAVE   = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int SCHEDULER  = 0,
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT    = 15
) (
    input  logic                           abus_clk,
    input  logic                           abus_rstb,
    input  logic [3*NB_MASTER-1:0]         abus_mid,
    input  logic [NB_MASTER-1:0]           abus_mreq,
    input  logic [NB_MASTER-1:0]           abus_mwrite,
    input  logic [NB_MASTER-1:0]           abus_mread,
    input  logic [NB_MASTER-1:0]           abus_mabort,
    input  logic [NB_MASTER*DATA_WIDTH-1:0] abus_mwdata,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0] abus_maddress,
    output logic [NB_MASTER-1:0]           abus_mgrant,
    output logic [NB_MASTER-1:0]           abus_mack,
    output logic [NB_MASTER-1:0]           abus_merr,
    output logic [DATA_WIDTH-1:0]          abus_mrdata,
    input  logic [NB_SLAVE-1:0]            abus_sack,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0] abus_srdata,
    output logic [NB_SLAVE-1:0]            abus_ssel,
    output logic [2:0]                     abus_smid,
    output logic                           abus_sreq,
    output logic                           abus_swrite,
    output logic                           abus_sread,
    output logic                           abus_sabort,
    output logic [ADDR_WIDTH-1:0]          abus_saddress,
    output logic [DATA_WIDTH-1:0]          abus_swdata
);

    localparam int MW = $clog2(NB_MASTER);
    localparam int unsigned NM = NB_MASTER;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_DECERR = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [NB_MASTER-1:0]  grant_q, grant_d;
    logic [NB_SLAVE-1:0]   ssel_q, ssel_d;
    logic [MW-1:0]         ptr_q, ptr_d;

    logic [MW-1:0]         owner;
    logic [MW-1:0]         win;
    logic                  win_found;
    int unsigned           idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [NB_SLAVE-1:0]   dec;
    logic                  hit;
    logic                  busy;
    logic                  ack_hit;
    logic                  own_abort;
    logic                  end_txn;
    logic                  sreq_c, sabort_c;
    logic [NB_MASTER-1:0]  mack_c, merr_c;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic                  wd_expire;

`ifdef ABUS_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;
    assign wd_expire = (wd_q == WDW'(TIMEOUT));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (grant_q[i]) owner = MW'(i);
        end
    end

    // Round robin scans from the pointer upward; fixed priority scans from index 0.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NM; k++) begin
            idx = (SCHEDULER == 0) ? ((32'(ptr_q) + k) % NM) : k;
            if (!win_found && abus_mreq[idx]) begin
                win_found = 1'b1;
                win       = MW'(idx);
            end
        end
    end

    assign win_addr = abus_maddress[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];

    // Overlapping windows resolve to the lowest slave index.
    always_comb begin
        dec = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NB_SLAVE; i++) begin
            if (!hit && ((win_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                         SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                dec[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign ack_hit   = |(abus_sack & ssel_q);
    assign own_abort = abus_mabort[owner] | ~abus_mreq[owner];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ssel_d   = ssel_q;
        ptr_d    = ptr_q;
`ifdef ABUS_ARB_TIMEOUT_EN
        wd_d     = wd_q;
`endif
        sreq_c   = 1'b0;
        sabort_c = 1'b0;
        mack_c   = '0;
        merr_c   = '0;
        end_txn  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|abus_mreq) begin
                    grant_d = NB_MASTER'(1) << win;
                    ssel_d  = dec;
                    state_d = hit ? S_BUSY : S_DECERR;
`ifdef ABUS_ARB_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            S_BUSY: begin
                sreq_c = 1'b1;
                // Ack beats both abort and watchdog expiry in the same cycle.
                if (ack_hit) begin
                    mack_c  = grant_q;
                    end_txn = 1'b1;
                end else if (own_abort) begin
                    sabort_c = 1'b1;
                    end_txn  = 1'b1;
                end else if (wd_expire) begin
                    sabort_c = 1'b1;
                    mack_c   = grant_q;
                    merr_c   = grant_q;
                    end_txn  = 1'b1;
                end else begin
`ifdef ABUS_ARB_TIMEOUT_EN
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            S_DECERR: begin
                mack_c  = grant_q;
                merr_c  = grant_q;
                end_txn = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                ssel_d  = '0;
            end
        endcase
        if (end_txn) begin
            state_d = S_IDLE;
            grant_d = '0;
            ssel_d  = '0;
            if (SCHEDULER == 0) begin
                ptr_d = (int'(owner) == NB_MASTER - 1) ? '0 : owner + MW'(1);
            end
        end
    end

    always_ff @(posedge abus_clk) begin
        if (!abus_rstb) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ssel_q  <= '0;
            ptr_q   <= '0;
`ifdef ABUS_ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ssel_q  <= ssel_d;
            ptr_q   <= ptr_d;
`ifdef ABUS_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        rdata_sel = '0;
        for (int unsigned i = 0; i < NB_SLAVE; i++) begin
            if (ssel_q[i]) rdata_sel = rdata_sel | abus_srdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Completion/abort strobes are suppressed while reset is asserted.
    assign abus_mack     = abus_rstb ? mack_c : '0;
    assign abus_merr     = abus_rstb ? merr_c : '0;
    assign abus_sabort   = abus_rstb & sabort_c;
    assign abus_sreq     = sreq_c;
    assign abus_mgrant   = grant_q;
    assign abus_ssel     = busy ? ssel_q : '0;
    assign abus_smid     = busy ? abus_mid[3*int'(owner) +: 3] : '0;
    assign abus_swrite   = busy & abus_mwrite[owner];
    assign abus_sread    = busy & abus_mread[owner];
    assign abus_saddress = busy ? abus_maddress[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign abus_swdata   = busy ? abus_mwdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign abus_mrdata   = (busy && ack_hit) ? rdata_sel : '0;

endmodule

// File: tb/tb_abus_arbiter_lock.sv
// Directed, table-driven bench for abus_arbiter_lock (4 masters, 2 slaves).
module tb_abus_arbiter_lock;

    localparam int NM = 4;
    localparam int NS = 2;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rstb;
    logic [3*NM-1:0]   mid;
    logic [NM-1:0]     mreq, mwrite, mread, mabort;
    logic [NM*DW-1:0]  mwdata;
    logic [NM*AW-1:0]  maddress;
    logic [NM-1:0]     mgrant, mack, merr;
    logic [DW-1:0]     mrdata;
    logic [NS-1:0]     sack;
    logic [NS*DW-1:0]  srdata;
    logic [NS-1:0]     ssel;
    logic [2:0]        smid;
    logic              sreq, swrite, sread, sabort;
    logic [AW-1:0]     saddress;
    logic [DW-1:0]     swdata;
    logic [68:0]       outs;

    int checks = 0;
    int errors = 0;

    logic [15:0] addr_tab [NM];

    always #5 clk = ~clk;

    abus_arbiter_lock #(
        .NB_MASTER (NM),
        .NB_SLAVE  (NS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SCHEDULER (0),
        .SLAVE_BASE(32'h8000_0000),
        .SLAVE_MASK(32'hF000_8000),
        .TIMEOUT   (4)
    ) dut (
        .abus_clk     (clk),
        .abus_rstb    (rstb),
        .abus_mid     (mid),
        .abus_mreq    (mreq),
        .abus_mwrite  (mwrite),
        .abus_mread   (mread),
        .abus_mabort  (mabort),
        .abus_mwdata  (mwdata),
        .abus_maddress(maddress),
        .abus_mgrant  (mgrant),
        .abus_mack    (mack),
        .abus_merr    (merr),
        .abus_mrdata  (mrdata),
        .abus_sack    (sack),
        .abus_srdata  (srdata),
        .abus_ssel    (ssel),
        .abus_smid    (smid),
        .abus_sreq    (sreq),
        .abus_swrite  (swrite),
        .abus_sread   (sread),
        .abus_sabort  (sabort),
        .abus_saddress(saddress),
        .abus_swdata  (swdata)
    );

    assign outs = {mgrant, mack, merr, mrdata, ssel, smid, sreq, swrite, sread, sabort, saddress, swdata};

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  abt;
        logic [1:0]  sack;
        logic [3:0]  grant;
        logic [1:0]  ssel;
        logic [3:0]  mack;
        logic [3:0]  merr;
        logic        sreq;
        logic        sabort;
        logic [15:0] rdata;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [3:0] rq, logic [3:0] ab, logic [1:0] sk,
                                logic [3:0] g, logic [1:0] ss, logic [3:0] ma,
                                logic [3:0] me, logic sq, logic sa, logic [15:0] rd);
        vec_t v;
        v.req = rq; v.abt = ab; v.sack = sk; v.grant = g; v.ssel = ss;
        v.mack = ma; v.merr = me; v.sreq = sq; v.sabort = sa; v.rdata = rd;
        return v;
    endfunction

    // Slave-side fields follow the owner: master i has ID 4+i, wdata 0x1000+i,
    // master 0 reads and the others write.
    function automatic logic [68:0] exp_outs(vec_t v);
        int          o = 0;
        logic [2:0]  em = '0;
        logic        ew = 1'b0;
        logic        er = 1'b0;
        logic [15:0] ea = '0;
        logic [15:0] ed = '0;
        for (int i = 0; i < NM; i++) if (v.grant[i]) o = i;
        if (v.sreq) begin
            em = 3'(4 + o);
            er = (o == 0);
            ew = (o != 0);
            ea = addr_tab[o];
            ed = 16'h1000 + 16'(o);
        end
        return {v.grant, v.mack, v.merr, v.rdata, v.ssel, em, v.sreq, ew, er, v.sabort, ea, ed};
    endfunction

    task automatic check(input string nm, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        @(posedge clk);
        #1;
        mreq   = v.req;
        mabort = v.abt;
        sack   = v.sack;
        @(negedge clk);
        check(nm, outs, exp_outs(v));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        addr_tab[0] = 16'h8004;
        addr_tab[1] = 16'h1234;
        addr_tab[2] = 16'hC000;
        addr_tab[3] = 16'h0010;
        for (int i = 0; i < NM; i++) begin
            maddress[i*AW +: AW] = addr_tab[i];
            mwdata[i*DW +: DW]   = 16'h1000 + 16'(i);
            mid[i*3 +: 3]        = 3'(4 + i);
        end
        mread  = 4'b0001;
        mwrite = 4'b1110;
        srdata = {16'hB1B1, 16'hA0A0};
        rstb   = 1'b0;
        mreq   = 4'b1111;
        mabort = '0;
        sack   = '0;

        // req abt sack | grant ssel mack merr sreq sabort rdata
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b10, 4'b0001, 2'b10, 4'b0001, 4'b0000, 1, 0, 16'hB1B1));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b01, 4'b0010, 2'b01, 4'b0010, 4'b0000, 1, 0, 16'hA0A0));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b0100, 2'b00, 4'b0100, 4'b0100, 0, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b1000, 2'b01, 4'b0000, 4'b0000, 1, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b01, 4'b1000, 2'b01, 4'b1000, 4'b0000, 1, 0, 16'hA0A0));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b0001, 2'b10, 4'b0000, 4'b0000, 1, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b0001, 2'b10, 4'b0000, 4'b0000, 1, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0001, 2'b00, 4'b0001, 2'b10, 4'b0000, 4'b0000, 1, 1, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        vt.push_back(mk(4'b1111, 4'b0010, 2'b01, 4'b0010, 2'b01, 4'b0010, 4'b0000, 1, 0, 16'hA0A0));
        vt.push_back(mk(4'b1001, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        vt.push_back(mk(4'b0001, 4'b0000, 2'b00, 4'b1000, 2'b01, 4'b0000, 4'b0000, 1, 1, 16'h0000));
        vt.push_back(mk(4'b0001, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        vt.push_back(mk(4'b0001, 4'b0000, 2'b10, 4'b0001, 2'b10, 4'b0001, 4'b0000, 1, 0, 16'hB1B1));
        vt.push_back(mk(4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        vt.push_back(mk(4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs, '0);
        rstb = 1'b1;
        mreq = '0;

        foreach (vt[i]) apply_vec(vt[i], $sformatf("vec%0d", i));

        // Stalled slave, master 1 (pointer now at 1).
        apply_vec(mk(4'b0010, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000), "wd_idle");
        for (int c = 1; c <= 4; c++)
            apply_vec(mk(4'b0010, 4'b0000, 2'b00, 4'b0010, 2'b01, 4'b0000, 4'b0000, 1, 0, 16'h0000),
                      $sformatf("wd_busy%0d", c));
`ifdef ABUS_ARB_TIMEOUT_EN
        apply_vec(mk(4'b0010, 4'b0000, 2'b00, 4'b0010, 2'b01, 4'b0010, 4'b0010, 1, 1, 16'h0000), "wd_expire");
        apply_vec(mk(4'b0010, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000), "wd_idle2");
        for (int c = 1; c <= 4; c++)
            apply_vec(mk(4'b0010, 4'b0000, 2'b00, 4'b0010, 2'b01, 4'b0000, 4'b0000, 1, 0, 16'h0000),
                      $sformatf("wd2_busy%0d", c));
        apply_vec(mk(4'b0010, 4'b0000, 2'b01, 4'b0010, 2'b01, 4'b0010, 4'b0000, 1, 0, 16'hA0A0), "wd_ack_wins");
`else
        for (int c = 5; c <= 20; c++)
            apply_vec(mk(4'b0010, 4'b0000, 2'b00, 4'b0010, 2'b01, 4'b0000, 4'b0000, 1, 0, 16'h0000),
                      $sformatf("nowd_busy%0d", c));
        apply_vec(mk(4'b0010, 4'b0000, 2'b01, 4'b0010, 2'b01, 4'b0010, 4'b0000, 1, 0, 16'hA0A0), "nowd_ack");
`endif
        apply_vec(mk(4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000), "idle_gap");

        // Reset during a stalled BUSY with the pointer at 2.
        apply_vec(mk(4'b0001, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000), "rst_idle");
        apply_vec(mk(4'b0001, 4'b0000, 2'b00, 4'b0001, 2'b10, 4'b0000, 4'b0000, 1, 0, 16'h0000), "rst_busy1");
        apply_vec(mk(4'b0001, 4'b0000, 2'b00, 4'b0001, 2'b10, 4'b0000, 4'b0000, 1, 0, 16'h0000), "rst_busy2");
        @(posedge clk);
        #1;
        rstb = 1'b0;
        mreq = 4'b0000;
        @(negedge clk);
        check("rst_no_strobe", 69'({mack, merr, sabort}), '0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        mreq = 4'b1110;
        @(negedge clk);
        check("rst_outputs_zero", outs, '0);
        apply_vec(mk(4'b1110, 4'b0000, 2'b01, 4'b0010, 2'b01, 4'b0010, 4'b0000, 1, 0, 16'hA0A0), "rst_ptr_zero");
        apply_vec(mk(4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 0, 0, 16'h0000), "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
